ysyx_alu_mul_pp_accum: RTL and testbench
========================================

Name: ysyx_alu_mul_pp_accum

Overview:
- Consumer end of the radix-4 Booth partial-product interface; sits between the Booth encoder and the MUL writeback.
- Accepts the 33 sign-extended, pre-shifted 128-bit partial products as a valid/ready stream, one per cycle.
- Reduces them in a carry-save register pair, then does one final 128-bit carry-propagate add.
- Returns the 128-bit product through a valid/ready result handshake.

Parameters:
- XLEN, 64, operand width; product width is 2*XLEN.
- NUM_PP, 33, maximum partial products per operation (XLEN/2+1).
- CNT_W, 6, width of the beat counter; must satisfy 2^CNT_W > NUM_PP.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous abort of the current operation.
- pp_valid_i  input  1  partial product present.
- pp_ready_o  output  1  accumulator can accept a partial product.
- pp_data_i  input  2*XLEN  partial product, already sign-extended and shifted into product position.
- pp_last_i  input  1  marks the final partial product of the operation.
- res_valid_o  output  1  product available.
- res_ready_i  input  1  downstream accepts the product.
- res_o  output  2*XLEN  product, mod 2^(2*XLEN).
- busy_o  output  1  at least one beat accepted and product not yet delivered.

Behaviour:
- Reset (asynchronous, rst_n_i low):
  - state=ACC; sum_q=0; carry_q=0; cnt_q=0; res_q=0.
  - Outputs: pp_ready_o=1, res_valid_o=0, res_o=0, busy_o=0.
- States:
  - ACC: pp_ready_o=1.
  - FINAL: pp_ready_o=0, one cycle.
  - DONE: pp_ready_o=0, res_valid_o=1.
- Beat accept = pp_valid_i & pp_ready_o.
- ACC, on accept:
  - sum_q <= sum_q ^ carry_q ^ pp_data_i.
  - carry_q <= majority(sum_q, carry_q, pp_data_i) << 1; bit 2*XLEN carry-out discarded.
  - cnt_q <= cnt_q + 1.
  - Go to FINAL if pp_last_i=1 or cnt_q==NUM_PP-1 (implicit last at beat 33; pp_last_i not required on beat 33).
- ACC with no accept: hold all state.
- FINAL: res_q <= sum_q + carry_q (mod 2^128); state <= DONE.
- DONE:
  - res_o=res_q, held stable while res_ready_i=0.
  - On res_ready_i=1: clear sum_q, carry_q and cnt_q; state <= ACC.
  - pp_ready_o rises the cycle after the handshake; no same-cycle overlap of result handshake and new beat.
- Latency: last beat accepted in cycle N -> res_valid_o=1 in cycle N+2. Minimum operation time is 1 beat + 2 cycles.
- res_o outside DONE: holds last res_q value (0 after reset). Consumers qualify it with res_valid_o.
- busy_o = (cnt_q!=0) | (state!=ACC).
- flush_i: highest priority in every state.
  - Next cycle: state=ACC, sum_q=0, carry_q=0, cnt_q=0, res_valid_o=0.
  - A beat presented in the flush cycle is dropped, even though pp_ready_o may be 1.
  - res_q is not cleared.
- Reset asserted mid-operation: immediate return to reset values; partial accumulation discarded, no result emitted.
- pp_valid_i while pp_ready_o=0: ignored. The producer holds pp_data_i/pp_last_i stable until accepted.
- Arithmetic: all 128-bit, modular. Sign handling is entirely in the incoming sign extension; no signedness input is needed.

Test Plan:
- Single beat pp_data_i=0x...0005 with pp_last_i=1 -> res_valid_o=1 two cycles later, res_o=0x5; busy_o=1 for cycles N+1..N+2.
- Two beats 0xFFFF...FFFF then 0x1 (last) -> res_o=0 (carry-out dropped).
- Full 33-beat Booth stream for unsigned 0xFFFFFFFFFFFFFFFF x 0xFFFFFFFFFFFFFFFF, no pp_last_i -> implicit last at beat 33, res_o=0xFFFFFFFFFFFFFFFE_0000000000000001.
- Same operands, signed -> res_o=0x1.
- Result backpressure: res_ready_i=0 for 5 cycles -> res_valid_o and res_o stable, pp_ready_o=0 throughout. pp_ready_o=1 the cycle after res_ready_i=1.
- Random pp_valid_i gaps with 7x(-3) signed streams -> res_o=0xFFFF...FFEB.
- flush_i after beat 10 -> next op 2x3 gives res_o=6.
- rst_n_i low mid-stream -> outputs at reset values immediately; next op 4x4 gives res_o=0x10.

Source files
------------

// File: rtl/ysyx_alu_mul_pp_accum.sv
// Radix-4 Booth partial-product accumulator: carry-save reduction of up to NUM_PP
// pre-shifted 2*XLEN-bit partial products, then a single carry-propagate add.
module ysyx_alu_mul_pp_accum #(
  parameter int XLEN   = 64,
  parameter int NUM_PP = 33,
  parameter int CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              pp_valid_i,
  output logic              pp_ready_o,
  input  logic [2*XLEN-1:0] pp_data_i,
  input  logic              pp_last_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [2*XLEN-1:0] res_o,
  output logic              busy_o
);

  localparam int W = 2 * XLEN;

  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_FINAL = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high. The producer holds data/last stable until accepted; ready never depends
  // on valid. The result side mirrors this with res_valid_o/res_ready_i.

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [W-1:0]     carry_q, carry_d;
  logic [W-1:0]     res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Internal observation point for checkers bound onto this block.
  logic [1:0]       state_dbg;
  assign state_dbg = state_q;

  logic         beat_acc;
  logic         beat_final;
  logic [W-1:0] csa_sum;
  logic [W-1:0] csa_maj;

  assign beat_acc   = pp_valid_i & pp_ready_o;
  assign beat_final = pp_last_i | (cnt_q == CNT_W'(NUM_PP - 1));

  // 3:2 compressor; the majority term moves up one weight and its top bit falls off.
  assign csa_sum = sum_q ^ carry_q ^ pp_data_i;
  assign csa_maj = (sum_q & carry_q) | (sum_q & pp_data_i) | (carry_q & pp_data_i);

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    if (flush_i) begin
      // Abort wins over everything; the last delivered product stays visible.
      state_d = ST_ACC;
      sum_d   = '0;
      carry_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (beat_acc) begin
            sum_d   = csa_sum;
            carry_d = {csa_maj[W-2:0], 1'b0};
            cnt_d   = cnt_q + CNT_W'(1);
            if (beat_final) state_d = ST_FINAL;
          end
        end
        ST_FINAL: begin
          res_d   = sum_q + carry_q;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          if (res_ready_i) begin
            sum_d   = '0;
            carry_d = '0;
            cnt_d   = '0;
            state_d = ST_ACC;
          end
        end
        default: begin
          state_d = ST_ACC;
          sum_d   = '0;
          carry_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_ACC;
      sum_q   <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign pp_ready_o  = (state_q == ST_ACC);
  assign res_valid_o = (state_q == ST_DONE);
  assign res_o       = res_q;
  assign busy_o      = (cnt_q != '0) | (state_q != ST_ACC);

endmodule

// File: tb/tb_ysyx_alu_mul_pp_accum.sv
// Bench for ysyx_alu_mul_pp_accum: Booth streams built from random operands,
// results compared against the plain 128-bit product.
module tb_ysyx_alu_mul_pp_accum;

  localparam int XLEN = 64;
  localparam int W    = 2 * XLEN;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         pp_valid;
  logic         pp_ready;
  logic [W-1:0] pp_data;
  logic         pp_last;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] pp_arr[33];
  logic [W-1:0] last_res;

  ysyx_alu_mul_pp_accum #(.XLEN(XLEN), .NUM_PP(33), .CNT_W(6)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .flush_i    (flush),
    .pp_valid_i (pp_valid),
    .pp_ready_o (pp_ready),
    .pp_data_i  (pp_data),
    .pp_last_i  (pp_last),
    .res_valid_o(res_valid),
    .res_ready_i(res_ready),
    .res_o      (res),
    .busy_o     (busy)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference: Booth digits and plain product ----------------
  task automatic gen_booth(input logic [63:0] a, input logic [63:0] b, input bit sgn,
                           output logic [W-1:0] prod);
    logic [W-1:0] xe;
    logic [W-1:0] ye128;
    logic [65:0]  ye;
    logic [2:0]   bits;
    logic [W-1:0] mag;
    xe    = sgn ? {{64{a[63]}}, a} : {64'b0, a};
    ye128 = sgn ? {{64{b[63]}}, b} : {64'b0, b};
    ye    = sgn ? {{2{b[63]}}, b} : {2'b00, b};
    prod  = xe * ye128;
    for (int i = 0; i < 33; i++) begin
      bits = {ye[2*i+1], ye[2*i], (i == 0) ? 1'b0 : ye[2*i-1]};
      case (bits)
        3'b001, 3'b010: mag = xe;
        3'b011:         mag = xe << 1;
        3'b100:         mag = -(xe << 1);
        3'b101, 3'b110: mag = -xe;
        default:        mag = '0;
      endcase
      pp_arr[i] = mag << (2 * i);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_beat(input logic [W-1:0] d, input logic last);
    bit acc;
    int guard;
    acc      = 1'b0;
    guard    = 0;
    pp_valid = 1'b1;
    pp_data  = d;
    pp_last  = last;
    while (!acc && guard < 100) begin
      acc = pp_ready;
      tick();
      guard++;
    end
    pp_valid = 1'b0;
    pp_last  = 1'b0;
    pp_data  = {$urandom, $urandom, $urandom, $urandom};
    if (!acc) check("beat_accept_timeout", W'(0), W'(1));
  endtask

  // Called in the cycle after the last beat was accepted.
  task automatic collect(input int hold, input string tag);
    logic [W-1:0] exp;
    check({tag, "_final_valid"}, W'(res_valid), W'(0));
    check({tag, "_final_busy"}, W'(busy), W'(1));
    check({tag, "_final_ready"}, W'(pp_ready), W'(0));
    tick();
    exp = exp_q.pop_front();
    check({tag, "_valid"}, W'(res_valid), W'(1));
    check({tag, "_res"}, res, exp);
    check({tag, "_done_busy"}, W'(busy), W'(1));
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, "_hold_valid"}, W'(res_valid), W'(1));
      check({tag, "_hold_res"}, res, exp);
      check({tag, "_hold_ready"}, W'(pp_ready), W'(0));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_post_ready"}, W'(pp_ready), W'(1));
    check({tag, "_post_valid"}, W'(res_valid), W'(0));
    check({tag, "_post_busy"}, W'(busy), W'(0));
    check({tag, "_post_res"}, res, exp);
    last_res = exp;
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input bit sgn,
                        input bit use_last, input int max_gap, input int hold, input string tag);
    logic [W-1:0] prod;
    gen_booth(a, b, sgn, prod);
    exp_q.push_back(prod);
    for (int i = 0; i < 33; i++) begin
      repeat ($urandom_range(max_gap, 0)) tick();
      drive_beat(pp_arr[i], use_last && (i == 32));
      if (i == 0) check({tag, "_busy_acc"}, W'(busy), W'(1));
    end
    collect(hold, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] prod;
    rst_n     = 1'b0;
    flush     = 1'b0;
    pp_valid  = 1'b0;
    pp_data   = '0;
    pp_last   = 1'b0;
    res_ready = 1'b0;
    last_res  = '0;
    #1;
    check("rst_ready", W'(pp_ready), W'(1));
    check("rst_valid", W'(res_valid), W'(0));
    check("rst_res", res, W'(0));
    check("rst_busy", W'(busy), W'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    exp_q.push_back(W'(5));
    drive_beat(W'(5), 1'b1);
    collect(0, "single");

    exp_q.push_back(W'(0));
    drive_beat({W{1'b1}}, 1'b0);
    check("wrap_busy", W'(busy), W'(1));
    drive_beat(W'(1), 1'b1);
    collect(0, "wrap");

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 0, "u_ff");
    check("u_ff_const", last_res, {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001});
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0, 5, "s_ff");
    check("s_ff_const", last_res, W'(1));
    run_op(64'd7, -64'sd3, 1'b1, 1'b1, 3, 2, "s_7x_m3");
    check("s_7x_m3_const", last_res, -W'(21));

    // Abort after ten beats; the beat offered during the flush cycle must be dropped.
    gen_booth(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b0, prod);
    for (int i = 0; i < 10; i++) drive_beat(pp_arr[i], 1'b0);
    pp_valid = 1'b1;
    pp_data  = pp_arr[10];
    flush    = 1'b1;
    check("flush_cycle_ready", W'(pp_ready), W'(1));
    tick();
    flush    = 1'b0;
    pp_valid = 1'b0;
    check("flush_busy", W'(busy), W'(0));
    check("flush_ready", W'(pp_ready), W'(1));
    check("flush_valid", W'(res_valid), W'(0));
    check("flush_res_kept", res, last_res);
    run_op(64'd2, 64'd3, 1'b0, 1'b1, 0, 0, "flush_2x3");

    // Flush while a result is waiting.
    drive_beat(W'(9), 1'b1);
    tick();
    check("done_flush_pre", W'(res_valid), W'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("done_flush_valid", W'(res_valid), W'(0));
    check("done_flush_res", res, W'(9));
    check("done_flush_busy", W'(busy), W'(0));

    // Reset in the middle of a stream.
    gen_booth(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_1111_1111, 1'b0, prod);
    for (int i = 0; i < 5; i++) drive_beat(pp_arr[i], 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", W'(pp_ready), W'(1));
    check("mid_rst_valid", W'(res_valid), W'(0));
    check("mid_rst_res", res, W'(0));
    check("mid_rst_busy", W'(busy), W'(0));
    tick();
    rst_n = 1'b1;
    tick();
    run_op(64'd4, 64'd4, 1'b0, 1'b1, 1, 0, "rst_4x4");
    check("rst_4x4_const", last_res, W'(16));

    for (int n = 0; n < 6; n++) begin
      run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1, 0)),
             1'($urandom_range(1, 0)), 2, $urandom_range(3, 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
